// File: rtl/axi_cache_arbiter_pkg.sv
// rtl/axi_cache_arbiter_pkg.sv - shared types for the i-cache/d-cache AXI arbiter
//
// Purpose: arbiter state and mux-select encodings, plus the state-to-select decode.
package axi_cache_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_READ  = 3'd1,
    D_READ  = 3'd2,
    D_WRITE = 3'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_I    = 2'd1,
    SEL_D    = 2'd2
  } arb_sel_t;

  localparam int STREAK_W = 4;

  function automatic arb_sel_t sel_of(arb_state_t s);
    case (s)
      I_READ:          return SEL_I;
      D_READ, D_WRITE: return SEL_D;
      default:         return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axi_cache_arbiter_if.sv
// rtl/axi_cache_arbiter_if.sv - request/grant/select and observed AXI handshakes
//
// Purpose: bundles the cache requests, grants, mux select and the shared R/B
// handshake signals the arbiter watches.
// master: cache/bus side (drives requests and AXI handshakes, receives grants)
// slave : arbiter side (receives requests and handshakes, drives grants/sel)
interface axi_cache_arbiter_if
  import axi_cache_arbiter_pkg::*;
;
  logic     i_req;
  logic     d_req;
  logic     d_req_write;
  logic     i_gnt;
  logic     d_gnt;
  arb_sel_t sel;
  logic     axi_rvalid;
  logic     axi_rready;
  logic     axi_rlast;
  logic     axi_bvalid;
  logic     axi_bready;

  modport master (
    output i_req, d_req, d_req_write,
    output axi_rvalid, axi_rready, axi_rlast, axi_bvalid, axi_bready,
    input  i_gnt, d_gnt, sel
  );

  modport slave (
    input  i_req, d_req, d_req_write,
    input  axi_rvalid, axi_rready, axi_rlast, axi_bvalid, axi_bready,
    output i_gnt, d_gnt, sel
  );

endinterface

// File: rtl/axi_cache_arbiter_watchdog.sv
// rtl/axi_cache_arbiter_watchdog.sv - grant hang watchdog
//
// Purpose: counts cycles a grant has been open; flags expiry on the last
// allowed cycle so the grant is dropped after exactly TIMEOUT_CYCLES cycles.
// Ports: clk, rst_n (async active-low), enable (state busy),
//        clear (state is changing), expired (combinational).
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_seen;

  // Busy cycles seen including the current one.
  assign w_seen  = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign expired = (TIMEOUT_CYCLES != 0) && enable &&
                   (w_seen == (CNT_W+1)'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || !enable) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_seen[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/axi_cache_arbiter.sv
// rtl/axi_cache_arbiter.sv - transaction-level AXI master port arbiter
//
// Purpose: grants whole AXI transactions to the i-cache (reads) or d-cache
// (refill reads / write-backs), detects completion from the shared R/B
// handshakes, enforces i-cache fairness and flags hangs/protocol anomalies.
// Ports: clk, rst_n (async active-low); bus (slave modport: requests in,
//        grants/sel out, AXI handshakes in); busy, timeout_err, proto_err,
//        arb_state debug outputs.
module axi_cache_arbiter
  import axi_cache_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axi_cache_arbiter_if.slave        bus,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      proto_err,
  output arb_state_t                arb_state
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_D_STREAK);

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic                r_i_gnt;
  logic                r_d_gnt;
  arb_sel_t            r_sel;
  logic                r_busy;
  logic                r_timeout;
  logic                r_proto;
  logic [STREAK_W-1:0] r_streak;

  logic w_r_hs;
  logic w_b_hs;
  logic w_r_done;
  logic w_expired;

  assign w_r_hs   = bus.axi_rvalid & bus.axi_rready;
  assign w_b_hs   = bus.axi_bvalid & bus.axi_bready;
  assign w_r_done = w_r_hs & bus.axi_rlast;

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (r_busy),
    .clear   (w_next != r_state),
    .expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        // d-cache wins ties until it has used its streak budget.
        if (bus.d_req && (!bus.i_req || (r_streak != MAX_S))) begin
          w_next = bus.d_req_write ? D_WRITE : D_READ;
        end else if (bus.i_req) begin
          w_next = I_READ;
        end
      end
      I_READ, D_READ: begin
        if (w_expired || w_r_done) begin
          w_next = IDLE;
        end
      end
      D_WRITE: begin
        if (w_expired) begin
          w_next = IDLE;
        end else if (w_b_hs) begin
          // Write-back followed by its refill keeps the port locked.
          w_next = (bus.d_req && !bus.d_req_write) ? D_READ : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_i_gnt   <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_sel     <= SEL_NONE;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_proto   <= 1'b0;
      r_streak  <= '0;
    end else begin
      r_state <= w_next;
      r_i_gnt <= (w_next == I_READ);
      r_d_gnt <= (w_next == D_READ) || (w_next == D_WRITE);
      r_sel   <= sel_of(w_next);
      r_busy  <= (w_next != IDLE);

      if (w_expired) begin
        r_timeout <= 1'b1;
      end
      if ((r_state == IDLE) && (w_r_hs || w_b_hs)) begin
        r_proto <= 1'b1;
      end

      // Streak only moves on arbitration from IDLE, so a lock never counts.
      if (r_state == IDLE) begin
        if (w_next == I_READ) begin
          r_streak <= '0;
        end else if ((w_next != IDLE) && bus.i_req) begin
          if (r_streak != MAX_S) begin
            r_streak <= r_streak + STREAK_W'(1);
          end
        end else if (!bus.i_req) begin
          r_streak <= '0;
        end
      end
    end
  end

  assign bus.i_gnt   = r_i_gnt;
  assign bus.d_gnt   = r_d_gnt;
  assign bus.sel     = r_sel;
  assign busy        = r_busy;
  assign timeout_err = r_timeout;
  assign proto_err   = r_proto;
  assign arb_state   = r_state;

endmodule
